// File: rtl/crc_engine_param_if.sv
// Handshake/bus bundle for crc_engine_param: request side plus result side.
interface crc_engine_param_if #(
  parameter int PKT_WIDTH = 55,
  parameter int CRC_WIDTH = 16,
  parameter int BPC       = 1
);
  localparam int COUNT_W = $clog2(PKT_WIDTH / BPC + 1);

  logic                 start;
  logic                 check_mode;
  logic [PKT_WIDTH-1:0] data_in;
  logic [CRC_WIDTH-1:0] rx_crc;
  logic                 busy;
  logic                 done;
  logic [CRC_WIDTH-1:0] crc_out;
  logic                 crc_match;
  logic [COUNT_W-1:0]   count;

  modport master (
    output start, check_mode, data_in, rx_crc,
    input  busy, done, crc_out, crc_match, count
  );

  modport slave (
    input  start, check_mode, data_in, rx_crc,
    output busy, done, crc_out, crc_match, count
  );
endinterface

// File: rtl/crc_engine_param.sv
// Parametrised MSB-first CRC generator/checker. A packet is latched on start,
// then BPC payload bits are folded into a Galois LFSR each cycle until the
// whole packet is consumed; the result (and in check mode the comparison
// against the received CRC) is published with a one-cycle done pulse.
module crc_engine_param #(
  parameter int                   PKT_WIDTH = 55,
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLY      = 16'h8005,
  parameter logic [CRC_WIDTH-1:0] INIT      = 16'hFFFF,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 16'h0000,
  parameter int                   BPC       = 1
) (
  input logic               clock,
  input logic               reset,
  crc_engine_param_if.slave bus
);

  localparam int                 STEPS   = PKT_WIDTH / BPC;
  localparam int                 COUNT_W = $clog2(STEPS + 1);
  localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CRC  = 2'd1
  } state_t;

  state_t               state_q, state_d;
  logic [PKT_WIDTH-1:0] shift_q, shift_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic                 mode_q, mode_d;
  logic [CRC_WIDTH-1:0] rx_q, rx_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CRC_WIDTH-1:0] crc_out_q, crc_out_d;
  logic                 match_q, match_d;

  logic [CRC_WIDTH-1:0] crc_step_val;
  logic [CRC_WIDTH-1:0] crc_final;

  // BPC serial bit steps unrolled; bits[BPC-1] is the earliest transmitted bit.
  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0] crc_in,
    input logic [BPC-1:0]       bits
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc_in;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = bits[i] ^ c[CRC_WIDTH-1];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // Next-state and next-output computation for the whole engine.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    mode_d       = mode_q;
    rx_d         = rx_q;
    count_d      = count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    crc_out_d    = crc_out_q;
    match_d      = match_q;
    crc_step_val = crc_step(crc_q, shift_q[PKT_WIDTH-1 -: BPC]);
    crc_final    = crc_step_val ^ XOR_OUT;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d = bus.data_in;
          mode_d  = bus.check_mode;
          rx_d    = bus.rx_crc;
          crc_d   = INIT;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_CRC;
        end
      end
      S_CRC: begin
        crc_d   = crc_step_val;
        shift_d = shift_q << BPC;
        count_d = count_q + COUNT_W'(1);
        if (count_q == LAST) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          crc_out_d = crc_final;
          match_d   = mode_q && (crc_final == rx_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts any packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      crc_q     <= INIT;
      mode_q    <= 1'b0;
      rx_q      <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_out_q <= INIT ^ XOR_OUT;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      mode_q    <= mode_d;
      rx_q      <= rx_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      crc_out_q <= crc_out_d;
      match_q   <= match_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.crc_match = match_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_crc_engine_param.sv
// Directed bench for crc_engine_param: four instances (72/1, 72/8, 55/1, 55/5)
// checked against hand values and a bit-serial reference CRC.
module tb_crc_engine_param;

  localparam logic [71:0] PAYLOAD = 72'h313233343536373839;

  logic clock;
  logic reset;

  logic        start_r [4];
  logic        mode_r  [4];
  logic [71:0] data_r  [4];
  logic [15:0] rx_r    [4];

  wire  [3:0]  busy_v;
  wire  [3:0]  done_v;
  wire  [3:0]  match_v;
  wire  [15:0] crc_v   [4];
  wire  [31:0] count_v [4];

  int vectors;
  int miscompares;

  crc_engine_param_if #(.PKT_WIDTH(72), .CRC_WIDTH(16), .BPC(1)) if72a ();
  crc_engine_param_if #(.PKT_WIDTH(72), .CRC_WIDTH(16), .BPC(8)) if72b ();
  crc_engine_param_if #(.PKT_WIDTH(55), .CRC_WIDTH(16), .BPC(1)) if55a ();
  crc_engine_param_if #(.PKT_WIDTH(55), .CRC_WIDTH(16), .BPC(5)) if55b ();

  crc_engine_param #(.PKT_WIDTH(72), .BPC(1)) u72a (.clock(clock), .reset(reset), .bus(if72a));
  crc_engine_param #(.PKT_WIDTH(72), .BPC(8)) u72b (.clock(clock), .reset(reset), .bus(if72b));
  crc_engine_param #(.PKT_WIDTH(55), .BPC(1)) u55a (.clock(clock), .reset(reset), .bus(if55a));
  crc_engine_param #(.PKT_WIDTH(55), .BPC(5)) u55b (.clock(clock), .reset(reset), .bus(if55b));

  assign if72a.start = start_r[0];
  assign if72b.start = start_r[1];
  assign if55a.start = start_r[2];
  assign if55b.start = start_r[3];
  assign if72a.check_mode = mode_r[0];
  assign if72b.check_mode = mode_r[1];
  assign if55a.check_mode = mode_r[2];
  assign if55b.check_mode = mode_r[3];
  assign if72a.data_in = data_r[0];
  assign if72b.data_in = data_r[1];
  assign if55a.data_in = data_r[2][54:0];
  assign if55b.data_in = data_r[3][54:0];
  assign if72a.rx_crc = rx_r[0];
  assign if72b.rx_crc = rx_r[1];
  assign if55a.rx_crc = rx_r[2];
  assign if55b.rx_crc = rx_r[3];

  assign busy_v  = {if55b.busy, if55a.busy, if72b.busy, if72a.busy};
  assign done_v  = {if55b.done, if55a.done, if72b.done, if72a.done};
  assign match_v = {if55b.crc_match, if55a.crc_match, if72b.crc_match, if72a.crc_match};
  assign crc_v[0] = if72a.crc_out;
  assign crc_v[1] = if72b.crc_out;
  assign crc_v[2] = if55a.crc_out;
  assign crc_v[3] = if55b.crc_out;
  assign count_v[0] = 32'(if72a.count);
  assign count_v[1] = 32'(if72b.count);
  assign count_v[2] = 32'(if55a.count);
  assign count_v[3] = 32'(if55b.count);

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the directed sequence itself hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Bit-serial reference: MSB-first, poly 0x8005, init 0xFFFF, no output XOR.
  function automatic logic [15:0] crc_ref(input logic [71:0] d, input int width);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = width - 1; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Launch one packet on instance idx and wait (bounded) for its done pulse.
  task automatic applyStimulus(input int idx, input logic [71:0] data,
                               input logic mode, input logic [15:0] rx,
                               output int busy_cycles, output logic got_done,
                               output logic [15:0] crc_at_accept);
    @(negedge clock);
    start_r[idx] = 1'b1;
    data_r[idx]  = data;
    mode_r[idx]  = mode;
    rx_r[idx]    = rx;
    @(negedge clock);
    start_r[idx]  = 1'b0;
    crc_at_accept = crc_v[idx];
    busy_cycles   = 0;
    got_done      = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_v[idx]) begin
        got_done = 1'b1;
        break;
      end
      if (busy_v[idx]) busy_cycles++;
      @(negedge clock);
    end
  endtask

  int          bc, bc2, bc3, cyc, last_done, pkts;
  logic        gd, gd2, gd3, seen_done, mode, flip;
  logic [15:0] ca, ca2, ca3, expc, rx;
  logic [71:0] d, da, db;
  logic [71:0] held_pl [3];

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 4; k++) begin
      start_r[k] = 1'b0;
      mode_r[k]  = 1'b0;
      data_r[k]  = '0;
      rx_r[k]    = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset values on every instance.
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("reset_busy%0d", k), 32'(busy_v[k]), 32'd0);
      checkOutput($sformatf("reset_done%0d", k), 32'(done_v[k]), 32'd0);
      checkOutput($sformatf("reset_crc%0d", k), 32'(crc_v[k]), 32'hFFFF);
      checkOutput($sformatf("reset_match%0d", k), 32'(match_v[k]), 32'd0);
      checkOutput($sformatf("reset_count%0d", k), count_v[k], 32'd0);
    end
    reset = 1'b0;

    // "123456789" generate mode, bit-serial.
    applyStimulus(0, PAYLOAD, 1'b0, 16'h0000, bc, gd, ca);
    checkOutput("gen72_done", 32'(gd), 32'd1);
    checkOutput("gen72_busy", 32'(bc), 32'd72);
    checkOutput("gen72_crc", 32'(crc_v[0]), 32'hAEE7);
    checkOutput("gen72_match", 32'(match_v[0]), 32'd0);
    checkOutput("gen72_count", count_v[0], 32'd72);
    @(negedge clock);
    checkOutput("gen72_pulse", 32'(done_v[0]), 32'd0);
    checkOutput("gen72_hold", 32'(crc_v[0]), 32'hAEE7);

    // Check mode with matching and non-matching received CRC.
    applyStimulus(0, PAYLOAD, 1'b1, 16'hAEE7, bc, gd, ca);
    checkOutput("chk_ok_done", 32'(gd), 32'd1);
    checkOutput("chk_ok_match", 32'(match_v[0]), 32'd1);
    checkOutput("chk_ok_crc", 32'(crc_v[0]), 32'hAEE7);
    applyStimulus(0, PAYLOAD, 1'b1, 16'hAEE6, bc, gd, ca);
    checkOutput("chk_bad_done", 32'(gd), 32'd1);
    checkOutput("chk_bad_match", 32'(match_v[0]), 32'd0);
    checkOutput("chk_bad_crc", 32'(crc_v[0]), 32'hAEE7);

    // Byte-wide engine on the same payload.
    applyStimulus(1, PAYLOAD, 1'b0, 16'h0000, bc, gd, ca);
    checkOutput("bpc8_done", 32'(gd), 32'd1);
    checkOutput("bpc8_busy", 32'(bc), 32'd9);
    checkOutput("bpc8_crc", 32'(crc_v[1]), 32'hAEE7);
    checkOutput("bpc8_count", count_v[1], 32'd9);

    // Random 55-bit packets, BPC=1 and BPC=5 side by side against the model.
    for (int p = 0; p < 500; p++) begin
      d        = '0;
      d[54:0]  = 55'({$urandom(), $urandom()});
      mode     = 1'($urandom_range(0, 1));
      flip     = 1'($urandom_range(0, 1));
      expc     = crc_ref(d, 55);
      rx       = expc ^ {15'd0, flip};
      fork
        applyStimulus(2, d, mode, rx, bc2, gd2, ca2);
        applyStimulus(3, d, mode, rx, bc3, gd3, ca3);
      join
      checkOutput($sformatf("rnd%0d_done1", p), 32'({gd2, gd3}), 32'b11);
      checkOutput($sformatf("rnd%0d_busy1", p), 32'(bc2), 32'd55);
      checkOutput($sformatf("rnd%0d_busy5", p), 32'(bc3), 32'd11);
      checkOutput($sformatf("rnd%0d_crc1", p), 32'(crc_v[2]), 32'(expc));
      checkOutput($sformatf("rnd%0d_crc5", p), 32'(crc_v[3]), 32'(expc));
      checkOutput($sformatf("rnd%0d_match", p), 32'({match_v[2], match_v[3]}),
                  (mode && !flip) ? 32'b11 : 32'b00);
    end

    // Reset in the middle of a 55-bit packet.
    d       = '0;
    d[54:0] = 55'({$urandom(), $urandom()});
    @(negedge clock);
    start_r[2] = 1'b1;
    data_r[2]  = d;
    mode_r[2]  = 1'b0;
    @(negedge clock);
    start_r[2] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (count_v[2] == 32'd20) break;
      @(negedge clock);
    end
    checkOutput("rst_reach20", count_v[2], 32'd20);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst_busy", 32'(busy_v[2]), 32'd0);
    checkOutput("rst_count", count_v[2], 32'd0);
    checkOutput("rst_crc", 32'(crc_v[2]), 32'hFFFF);
    checkOutput("rst_match", 32'(match_v[2]), 32'd0);
    reset     = 1'b0;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (done_v[2]) seen_done = 1'b1;
    end
    checkOutput("rst_no_done", 32'(seen_done), 32'd0);
    checkOutput("rst_crc_after", 32'(crc_v[2]), 32'hFFFF);

    // start pulsed mid-packet with different data must be ignored.
    da       = '0;
    db       = '0;
    da[54:0] = 55'({$urandom(), $urandom()});
    db[54:0] = ~da[54:0];
    @(negedge clock);
    start_r[2] = 1'b1;
    data_r[2]  = da;
    @(negedge clock);
    start_r[2] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (count_v[2] == 32'd10) break;
      @(negedge clock);
    end
    checkOutput("ign_reach10", count_v[2], 32'd10);
    data_r[2]  = db;
    start_r[2] = 1'b1;
    @(negedge clock);
    start_r[2] = 1'b0;
    gd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_v[2]) begin
        gd = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checkOutput("ign_done", 32'(gd), 32'd1);
    checkOutput("ign_crc", 32'(crc_v[2]), 32'(crc_ref(da, 55)));
    checkOutput("ign_count", count_v[2], 32'd55);

    // start held high across three back-to-back packets.
    held_pl[0] = PAYLOAD;
    held_pl[1] = 72'({$urandom(), $urandom(), $urandom()});
    held_pl[2] = 72'({$urandom(), $urandom(), $urandom()});
    @(negedge clock);
    data_r[0]  = held_pl[0];
    mode_r[0]  = 1'b0;
    start_r[0] = 1'b1;
    pkts      = 0;
    cyc       = 0;
    last_done = 0;
    for (int i = 0; i < 400 && pkts < 3; i++) begin
      @(negedge clock);
      cyc++;
      if (done_v[0]) begin
        checkOutput($sformatf("held%0d_crc", pkts), 32'(crc_v[0]),
                    32'(crc_ref(held_pl[pkts], 72)));
        if (pkts > 0)
          checkOutput($sformatf("held%0d_gap", pkts), 32'(cyc - last_done), 32'd73);
        last_done = cyc;
        pkts++;
        if (pkts < 3) data_r[0] = held_pl[pkts];
        else start_r[0] = 1'b0;
      end
    end
    start_r[0] = 1'b0;
    checkOutput("held_packets", 32'(pkts), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crc_engine_param.md
Name: crc_engine_param

Overview:
- Parametrised CRC generator/checker for the optical link packet path; next generation of the team's fixed 55-bit CRC-16 transmitter block.
- Generalises packet width, CRC width/polynomial/init/final XOR and bits processed per cycle.
- Adds a check mode that compares against a received CRC and flags the result; used on both the transmit side (generate) and the receive side (check).

Parameters:
- PKT_WIDTH, 55, payload bits per packet; must be a multiple of BPC.
- CRC_WIDTH, 16, CRC register width.
- POLY, 16'h8005, generator polynomial, implicit x^CRC_WIDTH term omitted.
- INIT, 16'hFFFF, register value loaded at start.
- XOR_OUT, 16'h0000, XORed into the register to form crc_out.
- BPC, 1, payload bits consumed per clock; legal values divide PKT_WIDTH.

Ports:
- clock  input  1  system clock, all logic posedge.
- reset  input  1  reset, synchronous, active-high; clock clock.
- start  input  1  request; sampled only in S_IDLE.
- check_mode  input  1  0 = generate, 1 = check; latched at start.
- data_in  input  PKT_WIDTH  payload, MSB transmitted first; latched at start.
- rx_crc  input  CRC_WIDTH  received CRC; latched at start, used only in check mode.
- busy  output  1  high while in S_CRC.
- done  output  1  one-cycle pulse when the result is valid.
- crc_out  output  CRC_WIDTH  final CRC (register ^ XOR_OUT); held until next start.
- crc_match  output  1  check mode: crc_out == latched rx_crc; generate mode: 0; held with crc_out.
- count  output  clog2(PKT_WIDTH/BPC+1)  steps completed in the current packet.

Behaviour:
- Reset values: busy=0, done=0, crc_out=INIT^XOR_OUT, crc_match=0, count=0, state=S_IDLE, internal register=INIT.
- Reset has priority over everything. Asserting it mid-packet aborts the packet: no done pulse, outputs return to their reset values.
- CRC is MSB-first, non-reflected Galois LFSR. Per bit b: fb = b ^ reg[CRC_WIDTH-1]; reg = (reg<<1) ^ (fb ? POLY : 0).
- With BPC>1, the per-cycle update is BPC sequential bit steps unrolled combinationally. It must equal the BPC=1 result bit-exactly.
- State S_IDLE:
  - start=1: latch data_in into a shift register, latch check_mode and rx_crc, load reg=INIT, count=0, busy=1, go to S_CRC.
  - start=0: hold all outputs; done=0.
- State S_CRC:
  - Each cycle consume the top BPC bits of the shift register, shift left by BPC, count+1.
  - When count reaches N-1 (N = PKT_WIDTH/BPC), the final step is applied, then the state returns to S_IDLE.
  - On that transition: busy=0, done=1 for exactly one cycle, crc_out updated, crc_match updated.
- Latency: start sampled at edge k → done high in the cycle after edge k+N. For BPC=1 that is exactly PKT_WIDTH cycles of busy.
- The first payload bit is processed on the first S_CRC cycle; no dead cycle and no dropped or extra bit.
- start while busy is ignored; inputs may change freely during S_CRC.
- start asserted in the same cycle done is high is accepted (S_IDLE was already reached), giving back-to-back packets with one idle cycle.
- start held continuously restarts a new packet each time S_IDLE is reached.
- crc_out and crc_match are stable from done until the edge that accepts the next start; they are not cleared by that start.
- count stops at N when the packet finishes and clears to 0 on the next accepted start.
- Unknown state encodings return to S_IDLE.

Test Plan:
- Default params with PKT_WIDTH=72, BPC=1, data_in=72'h313233343536373839 ("123456789"), generate mode → after 72 busy cycles done pulses, crc_out=16'hAEE7, crc_match=0.
- Same payload, check_mode=1, rx_crc=16'hAEE7 → crc_match=1. Repeat with rx_crc=16'hAEE6 → crc_match=0, crc_out still 16'hAEE7.
- PKT_WIDTH=72, BPC=8, same payload → done after 9 busy cycles, crc_out=16'hAEE7. Also 500 random 55-bit packets at BPC=1 vs BPC=5 vs a bit-serial model, all equal.
- Reset asserted at count=20 of a 55-bit packet → next cycle busy=0, count=0, crc_out=16'hFFFF; no done pulse follows.
- start pulsed at count=10 with a different data_in → ignored; result matches the first packet.
- start held high for 3 packets → done pulses spaced N+1 cycles apart, each crc_out correct for the data_in sampled at its accepting edge.
